// File: rtl/avalon_byte_mem_slave.sv
// Byte-wide Avalon-MM slave memory with programmable wait states, access counters and error flags.
// Read data is valid in the single cycle waitrequest is low; there is no readdatavalid.
module avalon_byte_mem_slave #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  OOR_DATA    = 8'hEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [7:0]  avs_s0_writedata,
    output logic [7:0]  avs_s0_readdata,
    output logic        avs_s0_waitrequest,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        oor_err,
    output logic        prot_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  readdata_q, readdata_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        oor_err_q, oor_err_d;
    logic        prot_err_q, prot_err_d;

    logic [7:0]  mem [DEPTH];

    logic                 req;
    logic                 complete;
    logic                 xfer_wr;
    logic [31:0]          xfer_addr;
    logic [7:0]           xfer_wdata;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;
    logic                 mem_we;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        avs_s0_waitrequest = (state_q != S_ACK);
    end

    // With zero wait states the transfer completes on the capture edge, so take fields straight off the bus
    always_comb begin
        req        = avs_s0_read | avs_s0_write;
        xfer_addr  = (state_q == S_IDLE) ? avs_s0_address   : addr_q;
        xfer_wdata = (state_q == S_IDLE) ? avs_s0_writedata : wdata_q;
        xfer_wr    = (state_q == S_IDLE) ? avs_s0_write     : is_wr_q;
        complete   = (state_d == S_ACK) && (state_q != S_ACK);
        in_range   = (xfer_addr < DEPTH);
        idx        = xfer_addr[ADDR_BITS-1:0];
        mem_we     = complete && xfer_wr && in_range;

        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        readdata_d = readdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        oor_err_d  = oor_err_q;
        prot_err_d = prot_err_q;

        if (state_q == S_IDLE && req) begin
            addr_d  = avs_s0_address;
            wdata_d = avs_s0_writedata;
            is_wr_d = avs_s0_write;
            if (avs_s0_read && avs_s0_write) prot_err_d = 1'b1;
        end

        if (complete) begin
            if (!in_range) oor_err_d = 1'b1;
            if (xfer_wr) begin
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                readdata_d = in_range ? mem[idx] : OOR_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            readdata_q <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            oor_err_q  <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            readdata_q <= readdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            oor_err_q  <= oor_err_d;
            prot_err_q <= prot_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= xfer_wdata;
    end

    assign avs_s0_readdata = readdata_q;
    assign rd_count        = rd_count_q;
    assign wr_count        = wr_count_q;
    assign oor_err         = oor_err_q;
    assign prot_err        = prot_err_q;

endmodule

// File: tb/tb_avalon_byte_mem_slave.sv
// Scoreboard bench for avalon_byte_mem_slave: dut 0 runs with 2 wait states, dut 1 with none.
module tb_avalon_byte_mem_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic [31:0] addr_s  [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [7:0]  wd_s    [2];
    logic [7:0]  rdata_s [2];
    logic        wreq_s  [2];
    logic [15:0] rdc_s   [2];
    logic [15:0] wrc_s   [2];
    logic        oor_s   [2];
    logic        prot_s  [2];

    avalon_byte_mem_slave #(
        .DEPTH(512), .ADDR_BITS(9), .WAIT_CYCLES(2), .OOR_DATA(8'hEE)
    ) u_dut_w2 (
        .clk(clk), .reset(rst_s[0]),
        .avs_s0_address(addr_s[0]), .avs_s0_read(rd_s[0]), .avs_s0_write(wr_s[0]),
        .avs_s0_writedata(wd_s[0]), .avs_s0_readdata(rdata_s[0]),
        .avs_s0_waitrequest(wreq_s[0]), .rd_count(rdc_s[0]), .wr_count(wrc_s[0]),
        .oor_err(oor_s[0]), .prot_err(prot_s[0])
    );

    avalon_byte_mem_slave #(
        .DEPTH(512), .ADDR_BITS(9), .WAIT_CYCLES(0), .OOR_DATA(8'hEE)
    ) u_dut_w0 (
        .clk(clk), .reset(rst_s[1]),
        .avs_s0_address(addr_s[1]), .avs_s0_read(rd_s[1]), .avs_s0_write(wr_s[1]),
        .avs_s0_writedata(wd_s[1]), .avs_s0_readdata(rdata_s[1]),
        .avs_s0_waitrequest(wreq_s[1]), .rd_count(rdc_s[1]), .wr_count(wrc_s[1]),
        .oor_err(oor_s[1]), .prot_err(prot_s[1])
    );

    typedef struct {
        logic [7:0]  data;
        int          ack_cyc;
        logic [15:0] rdc;
        logic [15:0] wrc;
        logic        oor;
        logic        prot;
    } item_t;

    item_t sb0[$];
    item_t sb1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         m_rdc  [2];
    int         m_wrc  [2];
    logic [7:0] m_last [2];
    logic       m_oor  [2];
    logic       m_prot [2];

    item_t mon_it;
    bit    mon_got;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every acknowledged transfer pops one expectation for that dut
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_s[d] === 1'b0 && wreq_s[d] === 1'b0) begin
                mon_got = 1'b0;
                if (d == 0 && sb0.size() > 0) begin
                    mon_it  = sb0.pop_front();
                    mon_got = 1'b1;
                end else if (d == 1 && sb1.size() > 0) begin
                    mon_it  = sb1.pop_front();
                    mon_got = 1'b1;
                end
                if (!mon_got) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack dut%0d: got ack required none (t=%0t)", d, $time);
                end else begin
                    chk($sformatf("ack_cycle_d%0d", d), cyc, mon_it.ack_cyc);
                    chk($sformatf("readdata_d%0d", d), {24'h0, rdata_s[d]}, {24'h0, mon_it.data});
                    chk($sformatf("rd_count_d%0d", d), {16'h0, rdc_s[d]}, {16'h0, mon_it.rdc});
                    chk($sformatf("wr_count_d%0d", d), {16'h0, wrc_s[d]}, {16'h0, mon_it.wrc});
                    chk($sformatf("oor_err_d%0d", d), {31'h0, oor_s[d]}, {31'h0, mon_it.oor});
                    chk($sformatf("prot_err_d%0d", d), {31'h0, prot_s[d]}, {31'h0, mon_it.prot});
                end
            end
        end
    end

    // Call aligned #1 after a posedge; returns aligned #1 after the ACK->IDLE posedge with the bus idle.
    task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input bit exp_oor,
                        input bit chg, input logic [31:0] alt);
        item_t it;
        int    w;
        bit    done;
        w = (d == 0) ? 2 : 0;
        rd_s[d]   = rd;
        wr_s[d]   = wr;
        addr_s[d] = a;
        wd_s[d]   = wd;
        if (wr) m_wrc[d]++;
        else begin
            m_rdc[d]++;
            m_last[d] = exp_rd;
        end
        if (exp_oor) m_oor[d] = 1'b1;
        if (rd && wr) m_prot[d] = 1'b1;
        it.data    = m_last[d];
        it.ack_cyc = cyc + 1 + w;
        it.rdc     = 16'(m_rdc[d]);
        it.wrc     = 16'(m_wrc[d]);
        it.oor     = m_oor[d];
        it.prot    = m_prot[d];
        if (d == 0) sb0.push_back(it);
        else        sb1.push_back(it);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (chg && i == 1) addr_s[d] = alt;
            if (wreq_s[d] === 1'b0) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout dut%0d addr %0h: got no ack required ack within 40 cycles", d, a);
        end
        @(posedge clk);
        #1;
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
    endtask

    task automatic wr_x(input int d, input logic [31:0] a, input logic [7:0] wd, input bit oor);
        xfer(d, 1'b0, 1'b1, a, wd, 8'h00, oor, 1'b0, 32'h0);
    endtask

    task automatic rd_x(input int d, input logic [31:0] a, input logic [7:0] exp, input bit oor);
        xfer(d, 1'b1, 1'b0, a, 8'h00, exp, oor, 1'b0, 32'h0);
    endtask

    task automatic chk_idle_state(input int d, input string tag);
        chk($sformatf("%s_waitreq_d%0d", tag, d), {31'h0, wreq_s[d]}, 32'h1);
        chk($sformatf("%s_readdata_d%0d", tag, d), {24'h0, rdata_s[d]}, 32'h0);
        chk($sformatf("%s_rd_count_d%0d", tag, d), {16'h0, rdc_s[d]}, 32'h0);
        chk($sformatf("%s_wr_count_d%0d", tag, d), {16'h0, wrc_s[d]}, 32'h0);
        chk($sformatf("%s_oor_d%0d", tag, d), {31'h0, oor_s[d]}, 32'h0);
        chk($sformatf("%s_prot_d%0d", tag, d), {31'h0, prot_s[d]}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int d = 0; d < 2; d++) begin
            rst_s[d]  = 1'b1;
            rd_s[d]   = 1'b0;
            wr_s[d]   = 1'b0;
            addr_s[d] = '0;
            wd_s[d]   = '0;
            m_rdc[d]  = 0;
            m_wrc[d]  = 0;
            m_last[d] = 8'h00;
            m_oor[d]  = 1'b0;
            m_prot[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_idle_state(0, "reset");
        chk_idle_state(1, "reset");
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(posedge clk);
        #1;

        // Basic write/read, readdata held across a write
        wr_x(0, 32'd7, 8'h5A, 1'b0);
        rd_x(0, 32'd7, 8'h5A, 1'b0);
        wr_x(0, 32'd8, 8'h77, 1'b0);
        rd_x(0, 32'd8, 8'h77, 1'b0);

        // Address range boundaries
        wr_x(0, 32'd3, 8'h3C, 1'b0);
        rd_x(0, 32'd512, 8'hEE, 1'b1);
        wr_x(0, 32'h0001_0003, 8'h99, 1'b1);
        rd_x(0, 32'd3, 8'h3C, 1'b1);
        wr_x(0, 32'd511, 8'hC3, 1'b1);
        rd_x(0, 32'd511, 8'hC3, 1'b1);

        // read and write together: write wins, prot_err set
        xfer(0, 1'b1, 1'b1, 32'd5, 8'h33, 8'h00, 1'b1, 1'b0, 32'h0);
        rd_x(0, 32'd5, 8'h33, 1'b1);

        // Address change during WAIT is ignored
        wr_x(0, 32'd9, 8'h99, 1'b1);
        xfer(0, 1'b1, 1'b0, 32'd7, 8'h00, 8'h5A, 1'b1, 1'b1, 32'd9);

        // Reset during WAIT of a write abandons it
        wr_x(0, 32'd4, 8'h44, 1'b1);
        wr_s[0]   = 1'b1;
        addr_s[0] = 32'd4;
        wd_s[0]   = 8'h11;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_waitreq_in_wait", {31'h0, wreq_s[0]}, 32'h1);
        rst_s[0] = 1'b1;
        #1;
        wr_s[0] = 1'b0;
        chk_idle_state(0, "abort");
        @(posedge clk);
        #1;
        rst_s[0]  = 1'b0;
        m_rdc[0]  = 0;
        m_wrc[0]  = 0;
        m_last[0] = 8'h00;
        m_oor[0]  = 1'b0;
        m_prot[0] = 1'b0;
        @(posedge clk);
        #1;
        rd_x(0, 32'd4, 8'h44, 1'b0);
        rd_x(0, 32'd9, 8'h99, 1'b0);

        // Zero-wait sweep: two cycles per back-to-back transfer
        c0 = cyc;
        for (int a = 0; a < 96; a++) wr_x(1, 32'(a), 8'(a) ^ 8'hA5, 1'b0);
        chk("sweep_write_cycles", cyc - c0, 32'd192);
        for (int a = 0; a < 96; a++) rd_x(1, 32'(a), 8'(a) ^ 8'hA5, 1'b0);
        chk("sweep_rd_count", {16'h0, rdc_s[1]}, 32'd96);
        chk("sweep_wr_count", {16'h0, wrc_s[1]}, 32'd96);

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drained", sb0.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
